// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Initiator side of the ALU operand/opcode interface. One decoded R-type
// request is accepted in IDLE, mapped onto the ALU's 3-bit Op / is_fp encoding,
// held stable on alu_* for the op's latency, and the captured result is then
// offered on a valid/ready writeback port. No request overlap: IDLE -> EXEC -> WB.
module alu_issue_ctrl #(
  parameter int XLEN       = 32,
  parameter int RD_W       = 5,
  parameter int FP_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            in_is_fp,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [RD_W-1:0] in_rd,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_is_fp,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            illegal
);

  // Counter must be able to hold the value FP_LATENCY itself.
  localparam int CNT_W = $clog2(FP_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   alu_a_q, alu_b_q, wb_data_q;
  logic [2:0]        alu_op_q;
  logic              alu_is_fp_q;
  logic [RD_W-1:0]   rd_q, wb_rd_q;
  logic              wb_valid_q, illegal_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [2:0]        dec_op;
  logic              dec_legal;
  logic              dec_shift;
  logic [XLEN-1:0]   dec_b;

  // Decode the incoming request into ALU Op, legality and shift-operand masking.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    dec_op    = in_funct3;
    dec_legal = 1'b0;
    dec_shift = 1'b0;
    if (in_is_fp) begin
      dec_legal = 1'b1;
    end else begin
      casez ({in_funct3, in_funct7_5})
        4'b000_0: begin dec_op = 3'b000; dec_legal = 1'b1; end  // ADD
        4'b000_1: begin dec_op = 3'b001; dec_legal = 1'b1; end  // SUB
        4'b111_?: begin dec_op = 3'b010; dec_legal = 1'b1; end  // AND
        4'b110_?: begin dec_op = 3'b011; dec_legal = 1'b1; end  // OR
        4'b100_?: begin dec_op = 3'b100; dec_legal = 1'b1; end  // XOR
        4'b001_0: begin dec_op = 3'b101; dec_legal = 1'b1; dec_shift = 1'b1; end  // SLL
        4'b101_1: begin dec_op = 3'b110; dec_legal = 1'b1; dec_shift = 1'b1; end  // SRA
        default:  begin dec_op = 3'b000; dec_legal = 1'b0; end
      endcase
    end
    // Shifts only ever see the 5-bit shift amount on operand B.
    dec_b = dec_shift ? {{(XLEN-5){1'b0}}, in_rs2[4:0]} : in_rs2;
  end

  // Issue FSM: accept, hold operands for the op latency, capture, write back.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 3'b000;
      alu_is_fp_q <= 1'b0;
      rd_q        <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (dec_legal) begin
              alu_a_q     <= in_rs1;
              alu_b_q     <= dec_b;
              alu_op_q    <= dec_op;
              alu_is_fp_q <= in_is_fp;
              rd_q        <= in_rd;
              cnt_q       <= CNT_W'(1);
              state_q     <= EXEC;
            end else begin
              // Unsupported request is consumed and only flagged.
              illegal_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (!alu_is_fp_q || (cnt_q == CNT_W'(FP_LATENCY))) begin
            wb_data_q  <= alu_result;
            wb_rd_q    <= rd_q;
            wb_valid_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= WB;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_is_fp = alu_is_fp_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: table of directed vectors, hand-written
// back-pressure and mid-op reset sequences, then random requests checked
// against a behavioural model of the R-type semantics.
module tb_alu_issue_ctrl;

  localparam int XLEN       = 32;
  localparam int RD_W       = 5;
  localparam int FP_LATENCY = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [2:0]      in_funct3;
  logic            in_funct7_5, in_is_fp;
  logic [XLEN-1:0] in_rs1, in_rs2;
  logic [RD_W-1:0] in_rd;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [2:0]      alu_op;
  logic            alu_is_fp;
  logic            wb_valid, wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            busy, illegal;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.XLEN(XLEN), .RD_W(RD_W), .FP_LATENCY(FP_LATENCY)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_fp(in_is_fp),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_fp(alu_is_fp),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Stand-in FP unit: any deterministic function of the held operands.
  function automatic logic [XLEN-1:0] fp_model(input logic [XLEN-1:0] a, b,
                                                input logic [2:0] op);
    return a * 3 + b + ({29'b0, op} << 8);
  endfunction

  // Combinational ALU responding to whatever the DUT drives (full B used for shifts).
  always_comb begin
    alu_result = '0;
    if (alu_is_fp) alu_result = fp_model(alu_a, alu_b, alu_op);
    else begin
      case (alu_op)
        3'b000: alu_result = alu_a + alu_b;
        3'b001: alu_result = alu_a - alu_b;
        3'b010: alu_result = alu_a & alu_b;
        3'b011: alu_result = alu_a | alu_b;
        3'b100: alu_result = alu_a ^ alu_b;
        3'b101: alu_result = alu_a << alu_b;
        3'b110: alu_result = $unsigned($signed(alu_a) >>> alu_b);
        default: alu_result = 32'hDEAD_BEEF;
      endcase
    end
  end

  typedef struct {
    logic [2:0]      f3;
    logic            f7;
    logic            fp;
    logic [XLEN-1:0] rs1, rs2;
    logic [RD_W-1:0] rd;
    logic            legal;
    logic [2:0]      op;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] data;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] f3, input logic f7, input logic fp,
                              input logic [XLEN-1:0] rs1, rs2, input logic [RD_W-1:0] rd,
                              input logic legal, input logic [2:0] op,
                              input logic [XLEN-1:0] b, data);
    vec_t v;
    v.f3 = f3; v.f7 = f7; v.fp = fp; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.legal = legal; v.op = op; v.b = b; v.data = data;
    return v;
  endfunction

  // Reference: R-type semantics straight from the instruction definitions.
  function automatic vec_t ref_model(input logic [2:0] f3, input logic f7, input logic fp,
                                     input logic [XLEN-1:0] rs1, rs2,
                                     input logic [RD_W-1:0] rd);
    vec_t v;
    logic [4:0] sh;
    v = mk(f3, f7, fp, rs1, rs2, rd, 1'b1, 3'b000, rs2, '0);
    sh = rs2[4:0];
    if (fp) begin
      v.op = f3; v.data = fp_model(rs1, rs2, f3);
    end else if (f3 == 3'd0) begin
      v.op = f7 ? 3'd1 : 3'd0; v.data = f7 ? rs1 - rs2 : rs1 + rs2;
    end else if (f3 == 3'd7) begin
      v.op = 3'd2; v.data = rs1 & rs2;
    end else if (f3 == 3'd6) begin
      v.op = 3'd3; v.data = rs1 | rs2;
    end else if (f3 == 3'd4) begin
      v.op = 3'd4; v.data = rs1 ^ rs2;
    end else if (f3 == 3'd1 && !f7) begin
      v.op = 3'd5; v.b = {27'b0, sh}; v.data = rs1 << sh;
    end else if (f3 == 3'd5 && f7) begin
      v.op = 3'd6; v.b = {27'b0, sh};
      v.data = $unsigned($signed(rs1) >>> sh);
    end else begin
      v.legal = 1'b0;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one request; hold = number of WB cycles with wb_ready low.
  task automatic run_op(input vec_t v, input int hold);
    int k;
    @(negedge clk);
    in_funct3 = v.f3; in_funct7_5 = v.f7; in_is_fp = v.fp;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
    in_valid = 1'b1;
    wb_ready = (hold == 0);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    if (!v.legal) begin
      in_valid = 1'b0;
      check("illegal_pulse", illegal, 1);
      check("illegal_in_ready", in_ready, 1);
      check("illegal_busy", busy, 0);
      check("illegal_no_wb", wb_valid, 0);
      @(posedge clk); #1;
      check("illegal_drop", illegal, 0);
      check("illegal_no_wb2", wb_valid, 0);
      return;
    end
    // Junk request while busy must be ignored.
    in_funct3 = ~v.f3; in_rs1 = ~v.rs1; in_rd = ~v.rd;
    check("exec_busy", busy, 1);
    check("exec_in_ready", in_ready, 0);
    check("exec_op", alu_op, v.op);
    check("exec_b", alu_b, v.b);
    check("exec_is_fp", alu_is_fp, v.fp);
    k = 1;
    while (!wb_valid && k < 100) begin
      check("exec_a_held", alu_a, v.rs1);
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    check("wb_latency", k, v.fp ? 1 + FP_LATENCY : 2);
    check("wb_data", wb_data, v.data);
    check("wb_rd", wb_rd, v.rd);
    check("wb_no_illegal", illegal, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("wb_hold_valid", wb_valid, 1);
      check("wb_hold_data", wb_data, v.data);
      check("wb_hold_rd", wb_rd, v.rd);
      check("wb_hold_op", alu_op, v.op);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    check("wb_done_valid", wb_valid, 0);
    check("wb_done_busy", busy, 0);
    check("wb_done_ready", in_ready, 1);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    tbl[0]  = mk(3'b000, 0, 0, 32'd5,          32'd3,          5'd7,  1, 3'b000, 32'd3,          32'd8);
    tbl[1]  = mk(3'b000, 1, 0, 32'd0,          32'd1,          5'd1,  1, 3'b001, 32'd1,          32'hFFFF_FFFF);
    tbl[2]  = mk(3'b101, 1, 0, 32'h8000_0000,  32'h24,         5'd2,  1, 3'b110, 32'd4,          32'hF800_0000);
    tbl[3]  = mk(3'b010, 0, 0, 32'd1,          32'd2,          5'd3,  0, 3'b000, 32'd0,          32'd0);
    tbl[4]  = mk(3'b111, 1, 0, 32'hF0F0_FF00,  32'h0FF0_F0F0,  5'd4,  1, 3'b010, 32'h0FF0_F0F0,  32'h00F0_F000);
    tbl[5]  = mk(3'b110, 0, 0, 32'hF000_0000,  32'h0000_000F,  5'd5,  1, 3'b011, 32'h0000_000F,  32'hF000_000F);
    tbl[6]  = mk(3'b100, 0, 0, 32'hFFFF_0000,  32'h0F0F_0F0F,  5'd6,  1, 3'b100, 32'h0F0F_0F0F,  32'hF0F0_0F0F);
    tbl[7]  = mk(3'b001, 0, 0, 32'd1,          32'hFFFF_FFE3,  5'd8,  1, 3'b101, 32'd3,          32'd8);
    tbl[8]  = mk(3'b101, 0, 0, 32'd16,         32'd1,          5'd9,  0, 3'b000, 32'd0,          32'd0);
    tbl[9]  = mk(3'b001, 1, 0, 32'd16,         32'd1,          5'd10, 0, 3'b000, 32'd0,          32'd0);
    tbl[10] = mk(3'b011, 0, 0, 32'd16,         32'd1,          5'd11, 0, 3'b000, 32'd0,          32'd0);
    tbl[11] = mk(3'b011, 0, 1, 32'd2,          32'd5,          5'd31, 1, 3'b011, 32'd5,          32'h30B);

    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
    in_funct3 = '0; in_funct7_5 = 1'b0; in_is_fp = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_illegal", illegal, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    foreach (tbl[i]) run_op(tbl[i], 0);

    // FP op with the consumer stalling for three WB cycles.
    run_op(mk(3'b010, 1, 1, 32'h10, 32'h1, 5'd19, 1, 3'b010, 32'h1, 32'h231), 3);

    // Reset in the second EXEC cycle of an FP op discards it.
    @(negedge clk);
    in_funct3 = 3'b001; in_funct7_5 = 1'b0; in_is_fp = 1'b1;
    in_rs1 = 32'h1234; in_rs2 = 32'h55; in_rd = 5'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fp_rst_exec1", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("fp_rst_wb_valid", wb_valid, 0);
    check("fp_rst_busy", busy, 0);
    check("fp_rst_alu_a", alu_a, 0);
    check("fp_rst_alu_b", alu_b, 0);
    check("fp_rst_alu_fp", alu_is_fp, 0);
    check("fp_rst_wb_data", wb_data, 0);
    check("fp_rst_in_ready", in_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    check("fp_rst_still_no_wb", wb_valid, 0);
    rst = 1'b0;
    run_op(tbl[0], 0);

    // Random requests against the behavioural model.
    for (int n = 0; n < 60; n++) begin
      rv = ref_model(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), $urandom, $urandom,
                     5'($urandom_range(0, 31)));
      run_op(rv, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
